// File: rtl/imem_pkg.sv
// imem_pkg: shared state encodings and constants for the instruction-memory access controller.
// Supplies a default for `INS_START_ADDRESS when the build does not define it.
`ifndef INS_START_ADDRESS
`define INS_START_ADDRESS 32'h0000_1000
`endif
package imem_pkg;
    localparam logic [31:0] DEF_BASE_ADDR = `INS_START_ADDRESS;
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;
endpackage

// File: rtl/imem_addr_check.sv
// imem_addr_check: maps a byte address to a word index and flags misaligned or out-of-array addresses.
module imem_addr_check #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 1001,
    parameter int          IDX_W     = 10
) (
    input  logic [31:0]      i_addr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_in_range
);
    logic [31:0] w_off;
    always_comb begin
        w_off      = i_addr - BASE_ADDR;
        o_idx      = w_off[IDX_W+1:2];
        o_in_range = (i_addr[1:0] == 2'b00) && (i_addr >= BASE_ADDR) && (w_off < 32'(DEPTH) * 32'd4);
    end
endmodule

// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl: owns the instruction-memory port; zero-fills after reset, then serves fetches and loader bursts.
// Optional IMEM_LOAD_CHECKSUM_EN adds ld_csum, the running sum of words written by the current burst.
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          DEPTH     = 1001,
    parameter int          IDX_W     = 10
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             core_req,
    input  logic [31:0]      core_pc,
    output logic             core_ack,
    output logic [31:0]      core_instr,
    output logic             core_stall,
    output logic             fetch_fault,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic             ld_err,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic [31:0]      ld_csum,
`endif
    output logic [IDX_W-1:0] mem_idx,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             init_done
);
    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_clr_cnt;
    logic               r_ack;
    logic [31:0]        r_instr;
    logic               r_fault;
    logic               r_ld_err;
    logic               r_init_done;
    logic [31:0]        w_addr;
    logic [IDX_W-1:0]   w_idx;
    logic               w_ok;
    logic               w_hs;
    logic               w_fetch;
    logic               w_enter_load;

    // One checker shared by both paths: LOAD owns the port, otherwise the fetch PC does.
    assign w_addr = (r_state == ST_LOAD) ? ld_addr : core_pc;

    imem_addr_check #(
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_addr_check (
        .i_addr     (w_addr),
        .o_idx      (w_idx),
        .o_in_range (w_ok)
    );

    always_comb begin
        w_next     = r_state;
        mem_we     = 1'b0;
        mem_idx    = '0;
        mem_wdata  = '0;
        ld_ready   = 1'b0;
        core_stall = 1'b1;
        w_hs       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                mem_we  = 1'b1;
                mem_idx = r_clr_cnt;
                w_next  = (r_clr_cnt == IDX_W'(DEPTH - 1)) ? ST_RUN : ST_CLEAR;
            end
            ST_RUN: begin
                core_stall = 1'b0;
                mem_idx    = (core_req && w_ok) ? w_idx : '0;
                w_next     = ld_valid ? ST_LOAD : ST_RUN;
            end
            ST_LOAD: begin
                ld_ready  = 1'b1;
                w_hs      = ld_valid;
                mem_we    = ld_valid && w_ok;
                mem_idx   = (ld_valid && w_ok) ? w_idx : '0;
                mem_wdata = (ld_valid && w_ok) ? ld_data : '0;
                w_next    = (ld_valid && ld_last) ? ST_RUN : ST_LOAD;
            end
            default: w_next = ST_CLEAR;
        endcase
        w_fetch      = (r_state == ST_RUN) && core_req;
        w_enter_load = (r_state == ST_RUN) && (w_next == ST_LOAD);
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= '0;
            r_ack       <= 1'b0;
            r_instr     <= '0;
            r_fault     <= 1'b0;
            r_ld_err    <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_clr_cnt   <= (r_state == ST_CLEAR) ? r_clr_cnt + IDX_W'(1) : r_clr_cnt;
            r_init_done <= r_init_done || ((r_state == ST_CLEAR) && (w_next == ST_RUN));
            r_ack       <= w_fetch;
            r_fault     <= w_fetch && !w_ok;
            r_instr     <= w_fetch ? (w_ok ? mem_rdata : NOP) : r_instr;
            r_ld_err    <= w_enter_load ? 1'b0 : (r_ld_err || (w_hs && !w_ok));
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] r_csum;
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset)
            r_csum <= '0;
        else
            r_csum <= w_enter_load ? 32'd0 : (mem_we && r_state == ST_LOAD) ? r_csum + ld_data : r_csum;
    end
    assign ld_csum = r_csum;
`endif

    assign core_ack    = r_ack;
    assign core_instr  = r_instr;
    assign fetch_fault = r_fault;
    assign ld_err      = r_ld_err;
    assign init_done   = r_init_done;
endmodule

// File: tb/tb_imem_access_ctrl.sv
// tb_imem_access_ctrl: directed bench for imem_access_ctrl with a behavioural single-port array.
module tb_imem_access_ctrl;
    localparam logic [31:0] B   = 32'h0000_1000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0;
    logic [31:0] core_pc = '0;
    logic        core_ack;
    logic [31:0] core_instr;
    logic        core_stall;
    logic        fetch_fault;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_err;
    logic [9:0]  mem_idx;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        init_done;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] ld_csum;
`endif

    logic [31:0] mem [0:1000];
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imem_access_ctrl #(.BASE_ADDR(B), .DEPTH(1001), .IDX_W(10)) dut (
        .SYS_clk     (clk),
        .SYS_reset   (rst),
        .core_req    (core_req),
        .core_pc     (core_pc),
        .core_ack    (core_ack),
        .core_instr  (core_instr),
        .core_stall  (core_stall),
        .fetch_fault (fetch_fault),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_err      (ld_err),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .ld_csum     (ld_csum),
`endif
        .mem_idx     (mem_idx),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .init_done   (init_done)
    );

    assign mem_rdata = (mem_idx < 10'd1001) ? mem[mem_idx] : 32'hxxxx_xxxx;

    always @(posedge clk) begin
        if (mem_we && mem_idx < 10'd1001) mem[mem_idx] <= mem_wdata;
        if (mem_we && !rst) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp_i, input logic exp_f);
        core_req = 1'b1;
        core_pc  = pc;
        #1;
        check("fetch_no_write", {31'd0, mem_we}, 32'd0);
        check("fetch_ack_early", {31'd0, core_ack}, 32'd0);
        if (exp_f) check("fault_no_idx", {22'd0, mem_idx}, 32'd0);
        step();
        core_req = 1'b0;
        check("fetch_ack", {31'd0, core_ack}, 32'd1);
        check("fetch_instr", core_instr, exp_i);
        check("fetch_fault", {31'd0, fetch_fault}, {31'd0, exp_f});
        step();
        check("fetch_ack_drop", {31'd0, core_ack}, 32'd0);
    endtask

    initial begin
        int n;
        int nz;
        for (int i = 0; i < 1001; i++) mem[i] = 32'hDEAD_BEEF;
        repeat (3) step();
        check("rst_ack", {31'd0, core_ack}, 32'd0);
        check("rst_instr", core_instr, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_ld_err", {31'd0, ld_err}, 32'd0);
        check("rst_init", {31'd0, init_done}, 32'd0);
        check("rst_stall", {31'd0, core_stall}, 32'd1);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("rst_csum", ld_csum, 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("clr_we", {31'd0, mem_we}, 32'd1);
        check("clr_idx0", {22'd0, mem_idx}, 32'd0);
        n = 0;
        while (!init_done && n < 2000) begin
            step();
            n++;
        end
        check("clr_cycles", n, 32'd1001);
        check("clr_writes", wr_cnt, 32'd1001);
        nz = 0;
        for (int i = 0; i < 1001; i++) if (mem[i] !== 32'd0) nz++;
        check("clr_zero", nz, 32'd0);

        // three-word burst
        ld_valid = 1'b1; ld_addr = B; ld_data = 32'd1; ld_last = 1'b0;
        #1;
        check("run_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("run_stall", {31'd0, core_stall}, 32'd0);
        step();
        check("ld_ready", {31'd0, ld_ready}, 32'd1);
        check("ld_stall0", {31'd0, core_stall}, 32'd1);
        check("ld_we0", {31'd0, mem_we}, 32'd1);
        check("ld_idx0", {22'd0, mem_idx}, 32'd0);
        check("ld_wdata0", mem_wdata, 32'd1);
        step();
        ld_addr = B + 32'd4; ld_data = 32'd2;
        #1;
        check("ld_idx1", {22'd0, mem_idx}, 32'd1);
        check("ld_stall1", {31'd0, core_stall}, 32'd1);
        step();
        ld_addr = B + 32'd8; ld_data = 32'd3; ld_last = 1'b1;
        #1;
        check("ld_idx2", {22'd0, mem_idx}, 32'd2);
        check("ld_stall2", {31'd0, core_stall}, 32'd1);
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("ld_back_ready", {31'd0, ld_ready}, 32'd0);
        check("ld_back_stall", {31'd0, core_stall}, 32'd0);
        check("mem0", mem[0], 32'd1);
        check("mem1", mem[1], 32'd2);
        check("mem2", mem[2], 32'd3);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("csum6", ld_csum, 32'd6);
`endif

        fetch(B, 32'd1, 1'b0);
        fetch(B + 32'd4, 32'd2, 1'b0);
        fetch(B + 32'd8, 32'd3, 1'b0);
        fetch(B + 32'd4000, 32'd0, 1'b0);
        fetch(B + 32'd2, NOP, 1'b1);
        fetch(B + 32'd4004, NOP, 1'b1);
        fetch(B - 32'd4, NOP, 1'b1);

        // dropped loader word
        ld_valid = 1'b1; ld_addr = B - 32'd4; ld_data = 32'hBAD0_BAD0; ld_last = 1'b1;
        step();
        check("bad_we", {31'd0, mem_we}, 32'd0);
        check("bad_ready", {31'd0, ld_ready}, 32'd1);
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("bad_err", {31'd0, ld_err}, 32'd1);
        step();
        check("bad_err_sticky", {31'd0, ld_err}, 32'd1);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("csum_cleared", ld_csum, 32'd0);
`endif

        // fetch and loader in the same RUN cycle
        core_req = 1'b1; core_pc = B + 32'd4;
        ld_valid = 1'b1; ld_addr = B + 32'd12; ld_data = 32'd4; ld_last = 1'b1;
        #1;
        check("both_idx", {22'd0, mem_idx}, 32'd1);
        step();
        core_pc = B;
        #1;
        check("both_ack", {31'd0, core_ack}, 32'd1);
        check("both_instr", core_instr, 32'd2);
        check("both_ready", {31'd0, ld_ready}, 32'd1);
        check("both_err_clr", {31'd0, ld_err}, 32'd0);
        check("both_we", {31'd0, mem_we}, 32'd1);
        check("both_widx", {22'd0, mem_idx}, 32'd3);
        step();
        core_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("load_req_ignored", {31'd0, core_ack}, 32'd0);
        check("both_back_ready", {31'd0, ld_ready}, 32'd0);
        fetch(B + 32'd12, 32'd4, 1'b0);

        // reset in the middle of a burst
        ld_valid = 1'b1; ld_addr = B - 32'd4; ld_data = 32'd9; ld_last = 1'b0;
        step();
        step();
        ld_addr = B + 32'd16; ld_data = 32'd5;
        #1;
        check("mid_err", {31'd0, ld_err}, 32'd1);
        check("mid_we", {31'd0, mem_we}, 32'd1);
        step();
        rst = 1'b1; ld_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("rr_err", {31'd0, ld_err}, 32'd0);
        check("rr_we", {31'd0, mem_we}, 32'd1);
        check("rr_idx0", {22'd0, mem_idx}, 32'd0);
        check("rr_stall", {31'd0, core_stall}, 32'd1);
        check("rr_ready", {31'd0, ld_ready}, 32'd0);
        check("rr_init", {31'd0, init_done}, 32'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("rr_csum", ld_csum, 32'd0);
`endif
        step();
        check("rr_idx1", {22'd0, mem_idx}, 32'd1);
        n = 1;
        while (!init_done && n < 2000) begin
            step();
            n++;
        end
        check("rr_cycles", n, 32'd1001);
        check("rr_mem4", mem[4], 32'd0);
        check("rr_mem0", mem[0], 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
